// File: rtl/cnt256_disp_scan_if.sv
// ============================================================================
//  Module   : cnt256_disp_scan_if
//  Brief    : Counter-value inputs and display-drive outputs of the scanner.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cnt256_disp_scan_if;
    logic [3:0] QH;
    logic [3:0] QL;
    logic       C;
    logic [6:0] Seg;
    logic       Dp;
    logic [1:0] Dig;
    logic [3:0] Wraps;

    // master: the counter side / environment; slave: the display scanner
    modport master (
        output QH, QL, C,
        input  Seg, Dp, Dig, Wraps
    );

    modport slave (
        input  QH, QL, C,
        output Seg, Dp, Dig, Wraps
    );
endinterface

`default_nettype wire

// File: rtl/cnt256_disp_scan.sv
// ============================================================================
//  Module   : cnt256_disp_scan
//  Brief    : Two-digit multiplexed 7-segment driver for an 8-bit hex counter
//             with per-frame capture, leading-zero blank and wrap flash/tally.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cnt256_disp_scan #(
    parameter int SCAN_DIV = 4,
    parameter int DP_HOLD  = 8,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic               Clk,
    input  logic               MR,
    cnt256_disp_scan_if.slave  bus
);

    localparam int             DIV_W    = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ZERO = '0;
    localparam logic [7:0]     DP_LOAD  = 8'(DP_HOLD);
    localparam logic [3:0]     WRAP_MAX = 4'hF;

    localparam logic [0:0]     SEL_LO   = 1'b0;
    localparam logic [0:0]     SEL_HI   = 1'b1;

    localparam logic [1:0]     DIG_LO   = 2'b01;
    localparam logic [1:0]     DIG_HI   = 2'b10;
    localparam logic [6:0]     SEG_OFF  = 7'h00;

    logic [DIV_W-1:0] div_cnt;
    logic [0:0]       sel;
    logic [0:0]       sel_next;
    logic [7:0]       shadow;
    logic             c_d;
    logic [7:0]       dp_cnt;
    logic [3:0]       wrap_cnt;

    logic             tick;
    logic             carry_edge;
    logic [3:0]       digit_val;
    logic             blank;
    logic [6:0]       seg_o;
    logic             dp_o;
    logic [1:0]       dig_o;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0:    hex7 = 7'h3F;
            4'h1:    hex7 = 7'h06;
            4'h2:    hex7 = 7'h5B;
            4'h3:    hex7 = 7'h4F;
            4'h4:    hex7 = 7'h66;
            4'h5:    hex7 = 7'h6D;
            4'h6:    hex7 = 7'h7D;
            4'h7:    hex7 = 7'h07;
            4'h8:    hex7 = 7'h7F;
            4'h9:    hex7 = 7'h6F;
            4'hA:    hex7 = 7'h77;
            4'hB:    hex7 = 7'h7C;
            4'hC:    hex7 = 7'h39;
            4'hD:    hex7 = 7'h5E;
            4'hE:    hex7 = 7'h79;
            default: hex7 = 7'h71;
        endcase
    endfunction

    assign tick       = (div_cnt == DIV_LAST);
    assign carry_edge = bus.C & ~c_d;

    // ------------------------------------------------------------------
    // Digit-select state machine: state register
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or negedge MR) begin
        if (!MR) begin
            sel <= SEL_LO;
        end else begin
            sel <= sel_next;
        end
    end

    // Next state: alternate digits on every divider tick
    always_comb begin
        sel_next = sel;
        if (tick) begin
            case (sel)
                SEL_LO:  sel_next = SEL_HI;
                default: sel_next = SEL_LO;
            endcase
        end
    end

    // Outputs: decoded purely from registered state, never from QH/QL/C
    always_comb begin
        dig_o     = DIG_LO;
        digit_val = shadow[3:0];
        blank     = 1'b0;
        dp_o      = 1'b0;
        case (sel)
            SEL_LO: begin
                dig_o     = DIG_LO;
                digit_val = shadow[3:0];
                dp_o      = (dp_cnt != 8'd0);
            end
            default: begin
                dig_o     = DIG_HI;
                digit_val = shadow[7:4];
                blank     = BLANK_LZ && (shadow[7:4] == 4'h0);
            end
        endcase
        seg_o = blank ? SEG_OFF : hex7(digit_val);
    end

    // ------------------------------------------------------------------
    // Scan divider
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or negedge MR) begin
        if (!MR) begin
            div_cnt <= DIV_ZERO;
        end else if (tick) begin
            div_cnt <= DIV_ZERO;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Capture only on the high->low boundary so a whole frame shows one value
    always_ff @(posedge Clk or negedge MR) begin
        if (!MR) begin
            shadow <= 8'h00;
        end else if (tick && (sel == SEL_HI)) begin
            shadow <= {bus.QH, bus.QL};
        end
    end

    // ------------------------------------------------------------------
    // Carry edge detect, decimal-point stretch and saturating wrap tally
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or negedge MR) begin
        if (!MR) begin
            c_d <= 1'b0;
        end else begin
            c_d <= bus.C;
        end
    end

    // A new edge restarts the flash rather than extending it
    always_ff @(posedge Clk or negedge MR) begin
        if (!MR) begin
            dp_cnt <= 8'd0;
        end else if (carry_edge) begin
            dp_cnt <= DP_LOAD;
        end else if (dp_cnt != 8'd0) begin
            dp_cnt <= dp_cnt - 8'd1;
        end
    end

    always_ff @(posedge Clk or negedge MR) begin
        if (!MR) begin
            wrap_cnt <= 4'h0;
        end else if (carry_edge && (wrap_cnt != WRAP_MAX)) begin
            wrap_cnt <= wrap_cnt + 4'h1;
        end
    end

    assign bus.Seg   = seg_o;
    assign bus.Dp    = dp_o;
    assign bus.Dig   = dig_o;
    assign bus.Wraps = wrap_cnt;

endmodule

`default_nettype wire

// File: tb/tb_cnt256_disp_scan.sv
// ============================================================================
//  Module   : tb_cnt256_disp_scan
//  Brief    : Directed self-checking bench for the two-digit display scanner.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cnt256_disp_scan;

    logic Clk;
    logic MR;
    int   n_cmp = 0;
    int   n_err = 0;

    cnt256_disp_scan_if bus_a ();
    cnt256_disp_scan_if bus_b ();

    // Second instance sees the same stimulus, with leading-zero blanking off
    assign bus_b.QH = bus_a.QH;
    assign bus_b.QL = bus_a.QL;
    assign bus_b.C  = bus_a.C;

    cnt256_disp_scan #(.SCAN_DIV(4), .DP_HOLD(8), .BLANK_LZ(1'b1)) dut_a (
        .Clk (Clk),
        .MR  (MR),
        .bus (bus_a)
    );

    cnt256_disp_scan #(.SCAN_DIV(4), .DP_HOLD(8), .BLANK_LZ(1'b0)) dut_b (
        .Clk (Clk),
        .MR  (MR),
        .bus (bus_b)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Expected Dig/Seg for cycles 0..16 after release with 0xA5, QL->3 at 9
    logic [1:0] cap_dig [17] = '{2'b01, 2'b01, 2'b01, 2'b01,
                                 2'b10, 2'b10, 2'b10, 2'b10,
                                 2'b01, 2'b01, 2'b01, 2'b01,
                                 2'b10, 2'b10, 2'b10, 2'b10,
                                 2'b01};
    logic [6:0] cap_seg [17] = '{7'h3F, 7'h3F, 7'h3F, 7'h3F,
                                 7'h00, 7'h00, 7'h00, 7'h00,
                                 7'h6D, 7'h6D, 7'h6D, 7'h6D,
                                 7'h77, 7'h77, 7'h77, 7'h77,
                                 7'h4F};
    // Expected Dp for cycles 17..27 after a carry edge at the end of cycle 16
    logic       flash_dp [11] = '{1'b1, 1'b1, 1'b1,
                                  1'b0, 1'b0, 1'b0, 1'b0,
                                  1'b1, 1'b0, 1'b0, 1'b0};

    task automatic step();
        @(negedge Clk);
    endtask

    // Leaves MR high at a falling edge: the caller is then in cycle 0
    task automatic reset_release();
        MR = 1'b0;
        step();
        step();
        MR = 1'b1;
    endtask

    task automatic test_reset();
        bus_a.QH = 4'hA;
        bus_a.QL = 4'h5;
        bus_a.C  = 1'b0;
        MR       = 1'b0;
        #1;
        n_cmp++;
        if (bus_a.Dig !== 2'b01 || bus_a.Seg !== 7'h3F || bus_a.Dp !== 1'b0 || bus_a.Wraps !== 4'h0) begin
            n_err++;
            $display("FAIL reset_async: Dig=%b Seg=%h Dp=%b Wraps=%0d, want 01 3F 0 0",
                     bus_a.Dig, bus_a.Seg, bus_a.Dp, bus_a.Wraps);
        end
        for (int i = 0; i < 3; i++) step();
        n_cmp++;
        if (bus_a.Dig !== 2'b01 || bus_a.Seg !== 7'h3F || bus_a.Dp !== 1'b0 || bus_a.Wraps !== 4'h0) begin
            n_err++;
            $display("FAIL reset_held: Dig=%b Seg=%h Dp=%b Wraps=%0d, want 01 3F 0 0",
                     bus_a.Dig, bus_a.Seg, bus_a.Dp, bus_a.Wraps);
        end
    endtask

    task automatic test_capture_no_tear();
        bus_a.QH = 4'hA;
        bus_a.QL = 4'h5;
        bus_a.C  = 1'b0;
        reset_release();
        for (int k = 0; k < 17; k++) begin
            n_cmp++;
            if (bus_a.Dig !== cap_dig[k] || bus_a.Seg !== cap_seg[k]) begin
                n_err++;
                $display("FAIL capture_cycle%0d: Dig=%b Seg=%h, want Dig=%b Seg=%h",
                         k, bus_a.Dig, bus_a.Seg, cap_dig[k], cap_seg[k]);
            end
            if (k == 9) bus_a.QL = 4'h3;
            step();
        end
    endtask

    task automatic test_leading_zero();
        bus_a.QH = 4'h0;
        bus_a.QL = 4'h7;
        bus_a.C  = 1'b0;
        reset_release();
        for (int k = 0; k < 16; k++) begin
            if (k >= 8 && k < 12) begin
                n_cmp++;
                if (bus_a.Seg !== 7'h07 || bus_b.Seg !== 7'h07 || bus_a.Dig !== 2'b01) begin
                    n_err++;
                    $display("FAIL lz_low_cycle%0d: SegA=%h SegB=%h DigA=%b, want 07 07 01",
                             k, bus_a.Seg, bus_b.Seg, bus_a.Dig);
                end
            end
            if (k >= 12) begin
                n_cmp++;
                if (bus_a.Seg !== 7'h00 || bus_a.Dig !== 2'b10 || bus_b.Seg !== 7'h3F || bus_b.Dig !== 2'b10) begin
                    n_err++;
                    $display("FAIL lz_high_cycle%0d: SegA=%h DigA=%b SegB=%h DigB=%b, want 00 10 3F 10",
                             k, bus_a.Seg, bus_a.Dig, bus_b.Seg, bus_b.Dig);
                end
            end
            step();
        end
    endtask

    task automatic test_carry_flash();
        bus_a.QH = 4'h1;
        bus_a.QL = 4'h2;
        bus_a.C  = 1'b0;
        reset_release();
        for (int k = 0; k < 16; k++) step();
        bus_a.C = 1'b1;
        n_cmp++;
        if (bus_a.Dp !== 1'b0 || bus_a.Wraps !== 4'h0) begin
            n_err++;
            $display("FAIL flash_pre_edge: Dp=%b Wraps=%0d, want 0 0", bus_a.Dp, bus_a.Wraps);
        end
        step();
        for (int k = 17; k < 28; k++) begin
            n_cmp++;
            if (bus_a.Dp !== flash_dp[k-17] || bus_a.Wraps !== 4'h1) begin
                n_err++;
                $display("FAIL flash_cycle%0d: Dp=%b Wraps=%0d, want Dp=%b Wraps=1",
                         k, bus_a.Dp, bus_a.Wraps, flash_dp[k-17]);
            end
            if (k == 18) bus_a.C = 1'b0;
            step();
        end
    endtask

    task automatic test_saturation_abort();
        logic [3:0] want;
        for (int i = 1; i <= 17; i++) begin
            bus_a.C = 1'b1;
            step();
            bus_a.C = 1'b0;
            step();
            want = (i + 1 > 15) ? 4'hF : 4'(i + 1);
            n_cmp++;
            if (bus_a.Wraps !== want) begin
                n_err++;
                $display("FAIL sat_pulse%0d: Wraps=%0d, want %0d", i, bus_a.Wraps, want);
            end
        end
        bus_a.C = 1'b1;
        step();
        bus_a.C = 1'b0;
        #2;
        MR = 1'b0;
        #1;
        n_cmp++;
        if (bus_a.Wraps !== 4'h0 || bus_a.Dp !== 1'b0 || bus_a.Dig !== 2'b01 || bus_a.Seg !== 7'h3F) begin
            n_err++;
            $display("FAIL abort_async: Wraps=%0d Dp=%b Dig=%b Seg=%h, want 0 0 01 3F",
                     bus_a.Wraps, bus_a.Dp, bus_a.Dig, bus_a.Seg);
        end
        step();
        MR = 1'b1;
        for (int k = 0; k < 5; k++) begin
            n_cmp++;
            if (bus_a.Dig !== ((k < 4) ? 2'b01 : 2'b10) || bus_a.Wraps !== 4'h0) begin
                n_err++;
                $display("FAIL abort_restart_cycle%0d: Dig=%b Wraps=%0d, want Dig=%b Wraps=0",
                         k, bus_a.Dig, bus_a.Wraps, (k < 4) ? 2'b01 : 2'b10);
            end
            step();
        end
    endtask

    initial begin
        MR       = 1'b0;
        bus_a.QH = 4'h0;
        bus_a.QL = 4'h0;
        bus_a.C  = 1'b0;
        step();
        test_reset();
        test_capture_no_tear();
        test_leading_zero();
        test_carry_flash();
        test_saturation_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, want completion");
        $fatal(1, "bench did not complete");
    end

endmodule

`default_nettype wire
